// File: rtl/data_mem_dump_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_dump_ctrl_pkg
//  Description : Shared FSM state encoding, memory addressing codes and small
//                helpers for the data-memory dump controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package data_mem_dump_ctrl_pkg;

    // Dump FSM states: IDLE hands the memory to the CPU, READ issues a word
    // read, HOLD presents the word to the consumer, DONE pulses completion.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } dump_state_e;

    // Memory access size codes shared by the CPU and memory ports.
    localparam logic [1:0] c_ADDR_WORD = 2'b00;
    localparam logic [1:0] c_ADDR_HALF = 2'b01;
    localparam logic [1:0] c_ADDR_BYTE = 2'b11;

    // The dump always walks memory one 32-bit word at a time.
    localparam int c_WORD_BYTES = 4;

    // The memory belongs to the dump engine in every state except IDLE.
    function automatic logic is_dump_active(input dump_state_e state);
        return (state != ST_IDLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_dump_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_dump_ctrl_if
//  Description : CPU-side and memory-side data bus bundle routed through the
//                dump controller. The slave modport is the controller view,
//                the master modport is the CPU/memory environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_dump_ctrl_if #(
    parameter int NB_DATA_BUS = 32,
    parameter int NB_ADDRESS  = 6
);

    // CPU side
    logic                   i_cpu_r_en;
    logic [NB_ADDRESS-1:0]  i_cpu_r_addr;
    logic [1:0]             i_cpu_r_addressing;
    logic                   i_cpu_w_en;
    logic [NB_ADDRESS-1:0]  i_cpu_w_addr;
    logic [NB_DATA_BUS-1:0] i_cpu_w_data;
    logic [1:0]             i_cpu_w_addressing;
    logic [NB_DATA_BUS-1:0] o_cpu_r_data;

    // Memory side
    logic                   o_mem_r_en;
    logic [NB_ADDRESS-1:0]  o_mem_r_addr;
    logic [1:0]             o_mem_r_addressing;
    logic                   o_mem_w_en;
    logic [NB_ADDRESS-1:0]  o_mem_w_addr;
    logic [NB_DATA_BUS-1:0] o_mem_w_data;
    logic [1:0]             o_mem_w_addressing;
    logic [NB_DATA_BUS-1:0] i_mem_r_data;

    modport slave (
        input  i_cpu_r_en, i_cpu_r_addr, i_cpu_r_addressing,
        input  i_cpu_w_en, i_cpu_w_addr, i_cpu_w_data, i_cpu_w_addressing,
        output o_cpu_r_data,
        output o_mem_r_en, o_mem_r_addr, o_mem_r_addressing,
        output o_mem_w_en, o_mem_w_addr, o_mem_w_data, o_mem_w_addressing,
        input  i_mem_r_data
    );

    modport master (
        output i_cpu_r_en, i_cpu_r_addr, i_cpu_r_addressing,
        output i_cpu_w_en, i_cpu_w_addr, i_cpu_w_data, i_cpu_w_addressing,
        input  o_cpu_r_data,
        input  o_mem_r_en, o_mem_r_addr, o_mem_r_addressing,
        input  o_mem_w_en, o_mem_w_addr, o_mem_w_data, o_mem_w_addressing,
        output i_mem_r_data
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_dump_ctrl_mem_port_mux.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_mux
//  Description : Selects who drives the data memory. With dump inactive the
//                CPU bus passes straight through; with dump active the dump
//                engine reads words and CPU writes/read data are suppressed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_mux
    import data_mem_dump_ctrl_pkg::*;
#(
    parameter int NB_DATA_BUS = 32,
    parameter int NB_ADDRESS  = 6
) (
    input  wire logic                   i_dump_active,
    input  wire logic                   i_dump_r_en,
    input  wire logic [NB_ADDRESS-1:0]  i_dump_r_addr,

    input  wire logic                   i_cpu_r_en,
    input  wire logic [NB_ADDRESS-1:0]  i_cpu_r_addr,
    input  wire logic [1:0]             i_cpu_r_addressing,
    input  wire logic                   i_cpu_w_en,
    input  wire logic [NB_ADDRESS-1:0]  i_cpu_w_addr,
    input  wire logic [NB_DATA_BUS-1:0] i_cpu_w_data,
    input  wire logic [1:0]             i_cpu_w_addressing,
    output logic      [NB_DATA_BUS-1:0] o_cpu_r_data,

    output logic                        o_mem_r_en,
    output logic      [NB_ADDRESS-1:0]  o_mem_r_addr,
    output logic      [1:0]             o_mem_r_addressing,
    output logic                        o_mem_w_en,
    output logic      [NB_ADDRESS-1:0]  o_mem_w_addr,
    output logic      [NB_DATA_BUS-1:0] o_mem_w_data,
    output logic      [1:0]             o_mem_w_addressing,
    input  wire logic [NB_DATA_BUS-1:0] i_mem_r_data
);

    // Pass-through by default; the dump engine overrides every port it owns.
    always_comb begin
        o_mem_r_en         = i_cpu_r_en;
        o_mem_r_addr       = i_cpu_r_addr;
        o_mem_r_addressing = i_cpu_r_addressing;
        o_mem_w_en         = i_cpu_w_en;
        o_mem_w_addr       = i_cpu_w_addr;
        o_mem_w_data       = i_cpu_w_data;
        o_mem_w_addressing = i_cpu_w_addressing;
        o_cpu_r_data       = i_mem_r_data;

        if (i_dump_active) begin
            o_mem_r_en         = i_dump_r_en;
            o_mem_r_addr       = i_dump_r_addr;
            o_mem_r_addressing = c_ADDR_WORD;
            // CPU writes are dropped so the dumped image stays consistent.
            o_mem_w_en         = 1'b0;
            o_mem_w_addr       = '0;
            o_mem_w_data       = '0;
            o_mem_w_addressing = c_ADDR_WORD;
            o_cpu_r_data       = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_dump_ctrl
//  Description : While the CPU pipeline is halted, walks the whole data
//                memory word by word and streams each word with its address
//                to a ready/valid consumer (debug UART). Otherwise the CPU
//                owns the memory through a transparent pass-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_dump_ctrl
    import data_mem_dump_ctrl_pkg::*;
#(
    parameter int NB_DATA_BUS = 32,
    parameter int N_ADDRESS   = 64,
    parameter int NB_ADDRESS  = $clog2(N_ADDRESS)
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_rst_n,

    data_mem_dump_ctrl_if.slave         bus,

    input  wire logic                   i_cpu_halt,
    input  wire logic                   i_dump_start,
    input  wire logic                   i_dump_ready,

    output logic                        o_dump_valid,
    output logic      [NB_DATA_BUS-1:0] o_dump_data,
    output logic      [NB_ADDRESS-1:0]  o_dump_addr,
    output logic                        o_dump_busy,
    output logic                        o_dump_done
);

    // Last word address of the memory; the counter stops here and never wraps.
    localparam logic [NB_ADDRESS-1:0] c_LAST_ADDR = NB_ADDRESS'(N_ADDRESS - c_WORD_BYTES);
    localparam logic [NB_ADDRESS-1:0] c_ADDR_STEP = NB_ADDRESS'(c_WORD_BYTES);

    dump_state_e            r_state_q;
    dump_state_e            w_state_d;
    logic [NB_ADDRESS-1:0]  r_cnt_q;
    logic [NB_ADDRESS-1:0]  w_cnt_d;
    logic                   r_dump_valid_q;
    logic                   w_dump_valid_d;
    logic [NB_DATA_BUS-1:0] r_dump_data_q;
    logic [NB_DATA_BUS-1:0] w_dump_data_d;
    logic [NB_ADDRESS-1:0]  r_dump_addr_q;
    logic [NB_ADDRESS-1:0]  w_dump_addr_d;
    logic                   r_dump_busy_q;
    logic                   w_dump_busy_d;
    logic                   r_dump_done_q;
    logic                   w_dump_done_d;

    logic                   w_dump_active;
    logic                   w_dump_r_en;

    // Next-state and next-output computation for the dump FSM.
    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_dump_data_d = r_dump_data_q;
        w_dump_addr_d = r_dump_addr_q;

        case (r_state_q)
            ST_IDLE: begin
                // A start without a halted pipeline is silently ignored.
                if (i_dump_start && i_cpu_halt) begin
                    w_state_d = ST_READ;
                    w_cnt_d   = '0;
                end
            end
            ST_READ: begin
                if (!i_cpu_halt) begin
                    w_state_d = ST_IDLE;
                end else begin
                    // Memory read is combinational, so capture it this cycle.
                    w_dump_data_d = bus.i_mem_r_data;
                    w_dump_addr_d = r_cnt_q;
                    w_state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!i_cpu_halt) begin
                    w_state_d = ST_IDLE;
                end else if (i_dump_ready) begin
                    if (r_cnt_q == c_LAST_ADDR) begin
                        w_state_d = ST_DONE;
                    end else begin
                        w_cnt_d   = r_cnt_q + c_ADDR_STEP;
                        w_state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        w_dump_valid_d = (w_state_d == ST_HOLD);
        w_dump_busy_d  = is_dump_active(w_state_d);
        w_dump_done_d  = (w_state_d == ST_DONE);
    end

    // FSM state, address counter and registered dump outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q      <= ST_IDLE;
            r_cnt_q        <= '0;
            r_dump_valid_q <= 1'b0;
            r_dump_data_q  <= '0;
            r_dump_addr_q  <= '0;
            r_dump_busy_q  <= 1'b0;
            r_dump_done_q  <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_dump_valid_q <= w_dump_valid_d;
            r_dump_data_q  <= w_dump_data_d;
            r_dump_addr_q  <= w_dump_addr_d;
            r_dump_busy_q  <= w_dump_busy_d;
            r_dump_done_q  <= w_dump_done_d;
        end
    end

    // Ownership comes straight from the state flop so a reset hands the
    // memory back to the CPU without waiting for a clock edge.
    assign w_dump_active = is_dump_active(r_state_q);
    assign w_dump_r_en   = (r_state_q == ST_READ);

    mem_port_mux #(
        .NB_DATA_BUS (NB_DATA_BUS),
        .NB_ADDRESS  (NB_ADDRESS)
    ) u_mem_port_mux (
        .i_dump_active      (w_dump_active),
        .i_dump_r_en        (w_dump_r_en),
        .i_dump_r_addr      (r_cnt_q),
        .i_cpu_r_en         (bus.i_cpu_r_en),
        .i_cpu_r_addr       (bus.i_cpu_r_addr),
        .i_cpu_r_addressing (bus.i_cpu_r_addressing),
        .i_cpu_w_en         (bus.i_cpu_w_en),
        .i_cpu_w_addr       (bus.i_cpu_w_addr),
        .i_cpu_w_data       (bus.i_cpu_w_data),
        .i_cpu_w_addressing (bus.i_cpu_w_addressing),
        .o_cpu_r_data       (bus.o_cpu_r_data),
        .o_mem_r_en         (bus.o_mem_r_en),
        .o_mem_r_addr       (bus.o_mem_r_addr),
        .o_mem_r_addressing (bus.o_mem_r_addressing),
        .o_mem_w_en         (bus.o_mem_w_en),
        .o_mem_w_addr       (bus.o_mem_w_addr),
        .o_mem_w_data       (bus.o_mem_w_data),
        .o_mem_w_addressing (bus.o_mem_w_addressing),
        .i_mem_r_data       (bus.i_mem_r_data)
    );

    assign o_dump_valid = r_dump_valid_q;
    assign o_dump_data  = r_dump_data_q;
    assign o_dump_addr  = r_dump_addr_q;
    assign o_dump_busy  = r_dump_busy_q;
    assign o_dump_done  = r_dump_done_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_dump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_dump_ctrl
//  Description : Self-checking bench for data_mem_dump_ctrl with a byte-wide
//                memory model and a scoreboard of expected dump words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_dump_ctrl;
    import data_mem_dump_ctrl_pkg::*;

    localparam int NB_DATA_BUS = 32;
    localparam int N_ADDRESS   = 64;
    localparam int NB_ADDRESS  = 6;
    localparam int N_WORDS     = N_ADDRESS / 4;

    typedef struct packed {
        logic [NB_ADDRESS-1:0]  addr;
        logic [NB_DATA_BUS-1:0] data;
    } exp_t;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n;
    logic                   i_cpu_halt;
    logic                   i_dump_start;
    logic                   i_dump_ready;
    logic                   o_dump_valid;
    logic [NB_DATA_BUS-1:0] o_dump_data;
    logic [NB_ADDRESS-1:0]  o_dump_addr;
    logic                   o_dump_busy;
    logic                   o_dump_done;

    logic [7:0]             mem     [N_ADDRESS];
    logic [7:0]             ref_mem [N_ADDRESS];
    logic                   preload;
    logic [NB_ADDRESS-1:0]  w_ra;
    logic [NB_ADDRESS-1:0]  w_wa;
    exp_t                   sb_q [$];
    int                     n_tests = 0;
    int                     n_fail  = 0;

    data_mem_dump_ctrl_if #(.NB_DATA_BUS(NB_DATA_BUS), .NB_ADDRESS(NB_ADDRESS)) bus ();

    data_mem_dump_ctrl #(
        .NB_DATA_BUS (NB_DATA_BUS),
        .N_ADDRESS   (N_ADDRESS),
        .NB_ADDRESS  (NB_ADDRESS)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .bus          (bus),
        .i_cpu_halt   (i_cpu_halt),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_data  (o_dump_data),
        .o_dump_addr  (o_dump_addr),
        .o_dump_busy  (o_dump_busy),
        .o_dump_done  (o_dump_done)
    );

    always #5 i_clk = ~i_clk;

    // Memory model: little-endian byte array, combinational read.
    always_comb begin
        w_ra = bus.o_mem_r_addr;
        case (bus.o_mem_r_addressing)
            c_ADDR_BYTE: bus.i_mem_r_data = {24'h0, mem[w_ra]};
            c_ADDR_HALF: bus.i_mem_r_data = {16'h0, mem[{w_ra[5:1], 1'b1}], mem[{w_ra[5:1], 1'b0}]};
            default:     bus.i_mem_r_data = {mem[{w_ra[5:2], 2'b11}], mem[{w_ra[5:2], 2'b10}],
                                             mem[{w_ra[5:2], 2'b01}], mem[{w_ra[5:2], 2'b00}]};
        endcase
    end

    // Memory model: synchronous write, plus preload of mem[i] = i.
    assign w_wa = bus.o_mem_w_addr;
    always @(posedge i_clk) begin
        if (preload) begin
            for (int i = 0; i < N_ADDRESS; i++) mem[i] <= 8'(i);
        end else if (bus.o_mem_w_en) begin
            case (bus.o_mem_w_addressing)
                c_ADDR_BYTE: mem[w_wa] <= bus.o_mem_w_data[7:0];
                c_ADDR_HALF: begin
                    mem[{w_wa[5:1], 1'b0}] <= bus.o_mem_w_data[7:0];
                    mem[{w_wa[5:1], 1'b1}] <= bus.o_mem_w_data[15:8];
                end
                default: begin
                    mem[{w_wa[5:2], 2'b00}] <= bus.o_mem_w_data[7:0];
                    mem[{w_wa[5:2], 2'b01}] <= bus.o_mem_w_data[15:8];
                    mem[{w_wa[5:2], 2'b10}] <= bus.o_mem_w_data[23:16];
                    mem[{w_wa[5:2], 2'b11}] <= bus.o_mem_w_data[31:24];
                end
            endcase
        end
    end

    function automatic logic [31:0] word_at(input int a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Runs one dump request. Cycle 0 is the cycle start is high.
    // stall_lo..stall_hi: ready low; halt_drop: halt falls from that cycle;
    // rst_at: reset pulsed in that cycle; exp_done: cycle of the done pulse.
    task automatic run_dump(input int stall_lo, input int stall_hi, input int halt_drop,
                            input int rst_at, input bit cpu_write, input int exp_done,
                            input int n_cycles);
        exp_t                  e;
        logic [NB_ADDRESS-1:0] stall_addr;
        stall_addr = NB_ADDRESS'(((stall_lo - 2) / 2) * 4);
        for (int k = 0; k < N_WORDS; k++) begin
            e.addr = NB_ADDRESS'(4 * k);
            e.data = word_at(4 * k);
            sb_q.push_back(e);
        end
        i_cpu_halt   = 1'b1;
        i_dump_ready = 1'b1;
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        for (int c = 1; c <= n_cycles; c++) begin
            i_dump_ready   = !(stall_lo > 0 && c >= stall_lo && c <= stall_hi);
            if (halt_drop > 0 && c >= halt_drop) i_cpu_halt = 1'b0;
            bus.i_cpu_w_en = cpu_write && (c < exp_done);
            @(negedge i_clk);
            if (o_dump_valid === 1'b1 && i_dump_ready) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: cycle %0d handshake addr %0d data %h, no word expected",
                             c, o_dump_addr, o_dump_data);
                end else begin
                    e = sb_q.pop_front();
                    if (o_dump_addr !== e.addr || o_dump_data !== e.data) begin
                        n_fail++;
                        $display("FAIL sb_word: cycle %0d got addr %0d data %h, want addr %0d data %h",
                                 c, o_dump_addr, o_dump_data, e.addr, e.data);
                    end
                end
            end
            if (c == 1) begin
                n_tests++;
                if (o_dump_valid !== 1'b0 || o_dump_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL read_cycle: valid=%b busy=%b, want valid=0 busy=1", o_dump_valid, o_dump_busy);
                end
            end
            if (c == 2) begin
                n_tests++;
                if (o_dump_valid !== 1'b1 || o_dump_addr !== '0) begin
                    n_fail++;
                    $display("FAIL first_valid: valid=%b addr=%0d, want valid=1 addr=0", o_dump_valid, o_dump_addr);
                end
            end
            if (stall_lo > 0 && c >= stall_lo && c <= stall_hi && c > 2) begin
                n_tests++;
                if (o_dump_valid !== 1'b1 || o_dump_addr !== stall_addr || o_dump_data !== word_at(int'(stall_addr))) begin
                    n_fail++;
                    $display("FAIL stall_hold: cycle %0d valid=%b addr=%0d data=%h, want 1 %0d %h",
                             c, o_dump_valid, o_dump_addr, o_dump_data, stall_addr, word_at(int'(stall_addr)));
                end
            end
            if (stall_lo > 0 && halt_drop == 0 && c == stall_hi + 1) begin
                n_tests++;
                if (o_dump_addr !== stall_addr) begin
                    n_fail++;
                    $display("FAIL stall_no_advance: addr=%0d, want %0d", o_dump_addr, stall_addr);
                end
            end
            if (halt_drop > 0 && c > halt_drop) begin
                n_tests++;
                if (o_dump_valid !== 1'b0 || o_dump_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_idle: cycle %0d valid=%b busy=%b, want 0 0", c, o_dump_valid, o_dump_busy);
                end
            end
            if (cpu_write && c < exp_done) begin
                n_tests++;
                if (bus.o_mem_w_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL w_en_blocked: cycle %0d o_mem_w_en=%b, want 0", c, bus.o_mem_w_en);
                end
            end
            n_tests++;
            if (o_dump_done !== (c == exp_done)) begin
                n_fail++;
                $display("FAIL done_pulse: cycle %0d done=%b, want %b", c, o_dump_done, (c == exp_done));
            end
            if (rst_at == c) begin
                #1 i_rst_n = 1'b0;
                #1;
                n_tests++;
                if ({o_dump_valid, o_dump_busy, o_dump_done} !== 3'b000 ||
                    o_dump_data !== '0 || o_dump_addr !== '0) begin
                    n_fail++;
                    $display("FAIL async_reset: valid=%b busy=%b done=%b data=%h addr=%0d, want all 0",
                             o_dump_valid, o_dump_busy, o_dump_done, o_dump_data, o_dump_addr);
                end
                @(negedge i_clk);
                i_rst_n = 1'b1;
                break;
            end
            tick();
        end
        bus.i_cpu_w_en = 1'b0;
        i_dump_ready   = 1'b1;
        i_cpu_halt     = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge i_clk);
        n_tests++;
        if ({o_dump_valid, o_dump_busy, o_dump_done} !== 3'b000 || o_dump_data !== '0 || o_dump_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b data=%h addr=%0d, want all 0",
                     o_dump_valid, o_dump_busy, o_dump_done, o_dump_data, o_dump_addr);
        end
        i_rst_n = 1'b1;
        tick();
        bus.i_cpu_r_en         = 1'b1;
        bus.i_cpu_r_addr       = 6'd8;
        bus.i_cpu_r_addressing = c_ADDR_WORD;
        #1;
        n_tests++;
        if (bus.o_mem_r_en !== 1'b1 || bus.o_mem_r_addr !== 6'd8 || bus.o_cpu_r_data !== 32'h0B0A0908) begin
            n_fail++;
            $display("FAIL idle_word_read: r_en=%b addr=%0d data=%h, want 1 8 0b0a0908",
                     bus.o_mem_r_en, bus.o_mem_r_addr, bus.o_cpu_r_data);
        end
        bus.i_cpu_r_addr       = 6'd10;
        bus.i_cpu_r_addressing = c_ADDR_HALF;
        #1;
        n_tests++;
        if (bus.o_mem_r_addressing !== c_ADDR_HALF || bus.o_cpu_r_data !== 32'h00000B0A) begin
            n_fail++;
            $display("FAIL idle_half_read: addressing=%b data=%h, want 01 00000b0a",
                     bus.o_mem_r_addressing, bus.o_cpu_r_data);
        end
        bus.i_cpu_r_en         = 1'b0;
        bus.i_cpu_r_addressing = c_ADDR_WORD;
        tick();
    endtask

    task automatic test_full_dump();
        run_dump(0, 0, 0, 0, 1'b0, 33, 36);
        n_tests++;
        if (sb_q.size() != 0 || o_dump_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_dump_end: words left %0d busy=%b, want 0 0", sb_q.size(), o_dump_busy);
        end
        sb_q.delete();
    endtask

    task automatic test_stall();
        run_dump(6, 10, 0, 0, 1'b0, 38, 41);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_end: words left %0d, want 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_abort();
        run_dump(12, 12, 12, 0, 1'b0, 0, 40);
        n_tests++;
        if (sb_q.size() != N_WORDS - 5) begin
            n_fail++;
            $display("FAIL abort_words: words left %0d, want %0d", sb_q.size(), N_WORDS - 5);
        end
        sb_q.delete();
    endtask

    task automatic test_write_blocked();
        int diffs;
        bus.i_cpu_w_addr       = 6'd12;
        bus.i_cpu_w_data       = 32'h12345678;
        bus.i_cpu_w_addressing = c_ADDR_WORD;
        run_dump(0, 0, 0, 0, 1'b1, 33, 36);
        diffs = 0;
        for (int i = 0; i < N_ADDRESS; i++) if (mem[i] !== ref_mem[i]) diffs++;
        n_tests++;
        if (diffs != 0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL mem_unchanged: %0d bytes differ, words left %0d, want 0 0", diffs, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_halt_low_start();
        i_cpu_halt   = 1'b0;
        i_dump_start = 1'b1;
        tick();
        i_dump_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            n_tests++;
            if (o_dump_busy !== 1'b0 || o_dump_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL start_ignored: busy=%b valid=%b, want 0 0", o_dump_busy, o_dump_valid);
            end
            tick();
        end
        bus.i_cpu_w_en         = 1'b1;
        bus.i_cpu_w_addr       = 6'd4;
        bus.i_cpu_w_data       = 32'hDEADBEEF;
        bus.i_cpu_w_addressing = c_ADDR_WORD;
        @(negedge i_clk);
        n_tests++;
        if (bus.o_mem_w_en !== 1'b1 || bus.o_mem_w_data !== 32'hDEADBEEF || bus.o_mem_w_addr !== 6'd4) begin
            n_fail++;
            $display("FAIL idle_write_pass: w_en=%b addr=%0d data=%h, want 1 4 deadbeef",
                     bus.o_mem_w_en, bus.o_mem_w_addr, bus.o_mem_w_data);
        end
        tick();
        bus.i_cpu_w_en = 1'b0;
        {ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4]} = 32'hDEADBEEF;
        @(negedge i_clk);
        n_tests++;
        if ({mem[7], mem[6], mem[5], mem[4]} !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL cpu_write_lands: mem word 4 = %h, want deadbeef", {mem[7], mem[6], mem[5], mem[4]});
        end
        bus.i_cpu_r_en   = 1'b1;
        bus.i_cpu_r_addr = 6'd4;
        #1;
        n_tests++;
        if (bus.o_cpu_r_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL cpu_readback: got %h, want deadbeef", bus.o_cpu_r_data);
        end
        bus.i_cpu_r_en = 1'b0;
        i_cpu_halt     = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        run_dump(4, 1000, 0, 6, 1'b0, 0, 10);
        n_tests++;
        if (sb_q.size() != N_WORDS - 1) begin
            n_fail++;
            $display("FAIL reset_words: words left %0d, want %0d", sb_q.size(), N_WORDS - 1);
        end
        sb_q.delete();
        tick();
        n_tests++;
        if (o_dump_busy !== 1'b0 || o_dump_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b valid=%b, want 0 0", o_dump_busy, o_dump_valid);
        end
        run_dump(0, 0, 0, 0, 1'b0, 33, 36);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL restart_end: words left %0d, want 0", sb_q.size());
        end
        sb_q.delete();
    endtask

    initial begin
        preload                = 1'b1;
        i_rst_n                = 1'b0;
        i_cpu_halt             = 1'b0;
        i_dump_start           = 1'b0;
        i_dump_ready           = 1'b0;
        bus.i_cpu_r_en         = 1'b0;
        bus.i_cpu_r_addr       = '0;
        bus.i_cpu_r_addressing = c_ADDR_WORD;
        bus.i_cpu_w_en         = 1'b0;
        bus.i_cpu_w_addr       = '0;
        bus.i_cpu_w_data       = '0;
        bus.i_cpu_w_addressing = c_ADDR_WORD;
        for (int i = 0; i < N_ADDRESS; i++) ref_mem[i] = 8'(i);
        repeat (2) @(posedge i_clk);
        #1 preload = 1'b0;

        test_reset();
        test_full_dump();
        test_stall();
        test_abort();
        test_write_blocked();
        test_halt_low_start();
        test_reset_mid_hold();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_dump_ctrl.md
DATA_MEM_DUMP_CTRL -- requirements
Module: data_mem_dump_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA_BUS, default 32, memory data-bus width in bits.
REQ-002 SHALL have parameter N_ADDRESS, default 64, memory size in bytes; multiple of 4.
REQ-003 SHALL have parameter NB_ADDRESS, default $clog2(N_ADDRESS), byte-address width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port i_clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have CPU ports i_cpu_r_en 1, i_cpu_r_addr NB_ADDRESS, i_cpu_r_addressing 2, i_cpu_w_en 1, i_cpu_w_addr NB_ADDRESS, i_cpu_w_data NB_DATA_BUS and i_cpu_w_addressing 2 (all inputs), plus o_cpu_r_data NB_DATA_BUS output.
REQ-008 SHALL have memory ports o_mem_r_en 1, o_mem_r_addr NB_ADDRESS, o_mem_r_addressing 2, o_mem_w_en 1, o_mem_w_addr NB_ADDRESS, o_mem_w_data NB_DATA_BUS and o_mem_w_addressing 2 (all outputs), plus i_mem_r_data NB_DATA_BUS input.
REQ-009 SHALL have port i_cpu_halt  input  1  pipeline halted; dump permitted only while high.
REQ-010 SHALL have port i_dump_start  input  1  one-cycle request to dump the whole memory.
REQ-011 SHALL have port i_dump_ready  input  1  consumer (debug UART) accepts current word.
REQ-012 SHALL have outputs o_dump_valid 1, o_dump_data NB_DATA_BUS, o_dump_addr NB_ADDRESS, o_dump_busy 1, and o_dump_done 1 (one-cycle completion pulse).

Function
REQ-013 SHALL implement FSM states IDLE, READ, HOLD, DONE.
REQ-014 In IDLE, all CPU inputs SHALL pass combinationally to the memory ports; o_cpu_r_data = i_mem_r_data.
REQ-015 IDLE->READ SHALL occur on i_dump_start=1 with i_cpu_halt=1; address counter loads 0.
REQ-016 i_dump_start with i_cpu_halt=0, or in any state other than IDLE, SHALL be ignored.
REQ-017 In READ: o_mem_r_en=1, o_mem_r_addressing=2'b00 (word), o_mem_r_addr=counter; i_mem_r_data registered into o_dump_data, counter into o_dump_addr; next state HOLD.
REQ-018 In HOLD: o_dump_valid=1, o_dump_data/o_dump_addr stable until handshake (valid & ready).
REQ-019 On handshake in HOLD: if counter==N_ADDRESS-4 -> DONE, else counter+=4 -> READ.
REQ-020 DONE SHALL assert o_dump_done for exactly one cycle, then return to IDLE.
REQ-021 Outside IDLE: o_mem_w_en=0 (CPU writes dropped), o_cpu_r_data=0, o_dump_busy=1.
REQ-022 i_cpu_halt falling in READ/HOLD SHALL abort to IDLE next edge: o_dump_valid drops, no o_dump_done.
REQ-023 Timing: i_dump_start edge -> first o_dump_valid 2 cycles later; with ready held high, one word per 2 cycles, N_ADDRESS/4 words total.
REQ-024 Counter SHALL be NB_ADDRESS bits; its last value is N_ADDRESS-4, so it never wraps.

Reset
REQ-025 i_rst_n=0 SHALL force IDLE, counter=0, o_dump_valid=0, o_dump_done=0, o_dump_busy=0, o_dump_data=0, o_dump_addr=0, regardless of clock.
REQ-026 Reset mid-dump SHALL discard the dump; after release the memory is owned by the CPU.

Structure
REQ-027 FSM state encodings and addressing codes (word 2'b00, half 2'b01, byte 2'b11) SHALL live in a shared package.
REQ-028 Memory-port muxing SHALL be a sub-module, mem_port_mux, selected by a single dump_active signal.

Verification
REQ-029 Bench SHALL cover: halt=1, start, ready=1, mem preloaded mem[i]=i -> 16 words, first 0x03020100 at addr 0, last 0x3F3E3D3C at addr 60, done pulse at cycle 33.
REQ-030 Bench SHALL cover: ready=0 for 5 cycles in HOLD at addr 8 -> valid held, data 0x0B0A0908 stable, no counter advance.
REQ-031 Bench SHALL cover: halt=0, start -> stays IDLE, busy=0, CPU word write 0xDEADBEEF to addr 4 lands in memory.
REQ-032 Bench SHALL cover: halt dropped while at addr 20 -> IDLE next cycle, valid=0, done never asserted.
REQ-033 Bench SHALL cover: CPU w_en=1 during dump -> o_mem_w_en=0, memory unchanged.
REQ-034 Bench SHALL cover: i_rst_n asserted mid-HOLD without clock edge -> outputs 0 immediately; restart dumps from addr 0.
